// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the access-size encoding (also used by the instruction decoder for
// data_size), the control FSM state encoding, the byte-enable base masks and
// a small helper that sign/zero-extends a byte or halfword lane.
package lsu_pkg;

    // Access size encoding, shared with the decoder's data_size output
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    // Byte-enable masks for a lane at offset 0; shifted by the byte offset
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Extend the low byte (is_half=0) or low halfword (is_half=1) of a lane
    // to 32 bits; zero_ext selects zero-extension instead of sign-extension.
    function automatic logic [31:0] extend_lane(input logic [15:0] lane,
                                                 input logic        is_half,
                                                 input logic        zero_ext);
        logic        sign_s;
        logic [31:0] res_s;
        if (is_half) begin
            sign_s = zero_ext ? 1'b0 : lane[15];
            res_s  = {{16{sign_s}}, lane};
        end else begin
            sign_s = zero_ext ? 1'b0 : lane[7];
            res_s  = {{24{sign_s}}, lane[7:0]};
        end
        return res_s;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment for the load/store unit.
// Ports:
//   size_i       access size (SZ_BYTE/SZ_HALF/SZ_WORD, SZ_ILL is illegal)
//   addr_lo_i    byte offset inside the word (addr[1:0])
//   store_data_i store value (rs2)
//   rdata_i      raw bus read word
//   unsigned_i   zero-extend load result
//   be_o         byte enables
//   wdata_o      store data replicated across all lanes
//   load_val_o   extracted and extended load value
//   misaligned_o access cannot be performed (bad alignment or illegal size)
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    input  logic        unsigned_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_val_o,
    output logic        misaligned_o
);

    logic [4:0]  shamt_s;
    logic [31:0] shifted_s;

    // Move the addressed lane of the read word down to bit 0
    always_comb begin
        shamt_s   = {addr_lo_i, 3'b000};
        shifted_s = rdata_i >> shamt_s;
    end

    // Decode enables, write replication, load extension and alignment
    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = 32'h0000_0000;
        load_val_o   = 32'h0000_0000;
        misaligned_o = 1'b1;
        case (size_i)
            SZ_BYTE: begin
                be_o         = BE_BYTE << addr_lo_i;
                wdata_o      = {4{store_data_i[7:0]}};
                load_val_o   = extend_lane(shifted_s[15:0], 1'b0, unsigned_i);
                misaligned_o = 1'b0;
            end
            SZ_HALF: begin
                be_o         = BE_HALF << addr_lo_i;
                wdata_o      = {2{store_data_i[15:0]}};
                load_val_o   = extend_lane(shifted_s[15:0], 1'b1, unsigned_i);
                misaligned_o = addr_lo_i[0];
            end
            SZ_WORD: begin
                be_o         = BE_WORD;
                wdata_o      = store_data_i;
                // Offset is 0 for any legal word access, so shifted == raw
                load_val_o   = shifted_s;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            default: begin
                be_o         = 4'b0000;
                wdata_o      = 32'h0000_0000;
                load_val_o   = 32'h0000_0000;
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: executes one load or store per start pulse on a
// single-master, word-wide data bus with a bounded wait for acknowledge.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   start                 one-cycle request pulse, accepted only when idle
//   data_r / data_w       load / store request from the decoder
//   data_size             SZ_BYTE/SZ_HALF/SZ_WORD (SZ_ILL faults)
//   unsigned_value        zero-extend the load result
//   addr, store_data      effective byte address, store value
//   busy, done, fault     status; done and fault are one-cycle pulses
//   load_data             extended load result, held until the next load
//   bus_req..bus_wdata    bus request side, held stable while requesting
//   bus_rdata, bus_ack    bus response side, rdata valid with ack
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        data_r,
    input  logic        data_w,
    input  logic [1:0]  data_size,
    input  logic        unsigned_value,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    // Counter value seen in the last unacknowledged cycle before giving up
    localparam bit              TO_EN     = (BUS_TIMEOUT != 0);
    localparam int unsigned     TO_LAST_I = TO_EN ? (BUS_TIMEOUT - 1) : 0;
    localparam logic [TO_W-1:0] TO_LAST   = TO_LAST_I[TO_W-1:0];

    lsu_state_e      state_q;
    logic [TO_W-1:0] cnt_q;
    logic [1:0]      size_q;
    logic [1:0]      addr_lo_q;
    logic            unsigned_q;

    logic            busy_q;
    logic            done_q;
    logic            fault_q;
    logic [31:0]     load_data_q;
    logic            bus_req_q;
    logic            bus_we_q;
    logic [31:0]     bus_addr_q;
    logic [3:0]      bus_be_q;
    logic [31:0]     bus_wdata_q;

    logic [1:0]      lane_size_s;
    logic [1:0]      lane_addr_lo_s;
    logic            lane_unsigned_s;
    logic [3:0]      be_s;
    logic [31:0]     wdata_s;
    logic [31:0]     load_val_s;
    logic            misaligned_s;
    logic            legal_s;
    logic            timeout_s;

    // The aligner serves the live request while idle (legality, enables,
    // write data) and the latched request afterwards (load extraction).
    always_comb begin
        lane_size_s     = size_q;
        lane_addr_lo_s  = addr_lo_q;
        lane_unsigned_s = unsigned_q;
        if (state_q == ST_IDLE) begin
            lane_size_s     = data_size;
            lane_addr_lo_s  = addr[1:0];
            lane_unsigned_s = unsigned_value;
        end else begin
            lane_size_s     = size_q;
            lane_addr_lo_s  = addr_lo_q;
            lane_unsigned_s = unsigned_q;
        end
    end

    lsu_lane_align u_lane_align (
        .size_i       (lane_size_s),
        .addr_lo_i    (lane_addr_lo_s),
        .store_data_i (store_data),
        .rdata_i      (bus_rdata),
        .unsigned_i   (lane_unsigned_s),
        .be_o         (be_s),
        .wdata_o      (wdata_s),
        .load_val_o   (load_val_s),
        .misaligned_o (misaligned_s)
    );

    // Request legality and timeout detection
    always_comb begin
        legal_s   = (data_r ^ data_w) & ~misaligned_s;
        timeout_s = TO_EN && (cnt_q == TO_LAST);
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            size_q      <= 2'b00;
            addr_lo_q   <= 2'b00;
            unsigned_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            load_data_q <= 32'h0000_0000;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        size_q     <= data_size;
                        addr_lo_q  <= addr[1:0];
                        unsigned_q <= unsigned_value;
                        if (legal_s) begin
                            state_q     <= ST_REQ;
                            cnt_q       <= '0;
                            busy_q      <= 1'b1;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= data_w;
                            bus_addr_q  <= {addr[31:2], 2'b00};
                            bus_be_q    <= be_s;
                            bus_wdata_q <= wdata_s;
                        end else begin
                            fault_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // Acknowledge takes priority over a coincident timeout
                    if (bus_ack) begin
                        state_q   <= ST_RESP;
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        if (!bus_we_q) begin
                            load_data_q <= load_val_s;
                        end
                    end else if (timeout_s) begin
                        state_q   <= ST_IDLE;
                        bus_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        fault_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign load_data = load_data_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit, timeout configured to 4 cycles.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        data_r;
    logic        data_w;
    logic [1:0]  data_size;
    logic        unsigned_value;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int          checks;
    int          failures;
    logic [31:0] model_ld;

    load_store_unit #(
        .BUS_TIMEOUT (4),
        .TO_W        (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .data_r         (data_r),
        .data_w         (data_w),
        .data_size      (data_size),
        .unsigned_value (unsigned_value),
        .addr           (addr),
        .store_data     (store_data),
        .busy           (busy),
        .done           (done),
        .fault          (fault),
        .load_data      (load_data),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_be         (bus_be),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .bus_ack        (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference rules written as plain arithmetic
    function automatic logic ref_legal(input logic r, input logic w, input logic [1:0] sz,
                                       input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (r == w) return 1'b0;
        if (sz == 2'd3) return 1'b0;
        if (sz == 2'd1 && (off % 2) != 0) return 1'b0;
        if (sz == 2'd2 && off != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] sd);
        if (sz == 2'd0) return (sd & 32'h0000_00FF) * 32'h0101_0101;
        if (sz == 2'd1) return (sd & 32'h0000_FFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(a[1:0]));
        if (sz == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One complete request; dly = REQ cycles without ack before the ack cycle
    task automatic do_op(input logic r, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                         input int dly, input bit spurious);
        logic        legal;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        legal = ref_legal(r, w, sz, a);
        e_be  = ref_be(sz, a);
        e_wd  = ref_wdata(sz, sd);
        start = 1'b1; data_r = r; data_w = w; data_size = sz; unsigned_value = u;
        addr = a; store_data = sd;
        @(posedge clk); #1;
        start = 1'b0;
        data_r = 1'($urandom); data_w = 1'($urandom); data_size = 2'($urandom);
        unsigned_value = 1'($urandom); addr = $urandom; store_data = $urandom;
        if (!legal) begin
            chk1("illegal_fault", fault, 1'b1);
            chk1("illegal_no_req", bus_req, 1'b0);
            chk1("illegal_not_busy", busy, 1'b0);
            chk32("illegal_ld_hold", load_data, model_ld);
            @(posedge clk); #1;
            chk1("illegal_fault_pulse", fault, 1'b0);
            chk1("illegal_no_req2", bus_req, 1'b0);
        end else begin
            chk1("req_asserted", bus_req, 1'b1);
            chk1("busy_asserted", busy, 1'b1);
            chk1("no_fault", fault, 1'b0);
            chk32("bus_addr", bus_addr, {a[31:2], 2'b00});
            chk32("bus_be", 32'(bus_be), 32'(e_be));
            if (w) chk32("bus_wdata", bus_wdata, e_wd);
            chk1("bus_we", bus_we, w);
            for (int i = 0; i < dly; i++) begin
                if (spurious && i == 0) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk1("req_held", bus_req, 1'b1);
                chk32("addr_stable", bus_addr, {a[31:2], 2'b00});
                chk32("be_stable", 32'(bus_be), 32'(e_be));
                chk1("we_stable", bus_we, w);
            end
            bus_ack = 1'b1; bus_rdata = rd;
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_rdata = $urandom;
            if (r) model_ld = ref_load(sz, u, a, rd);
            chk1("done_pulse", done, 1'b1);
            chk1("req_dropped", bus_req, 1'b0);
            chk1("busy_in_resp", busy, 1'b1);
            chk1("no_fault_resp", fault, 1'b0);
            chk32("load_data", load_data, model_ld);
            @(posedge clk); #1;
            chk1("done_cleared", done, 1'b0);
            chk1("busy_cleared", busy, 1'b0);
            chk1("req_idle", bus_req, 1'b0);
        end
    endtask

    // Acknowledge while idle must have no effect
    task automatic idle_ack();
        bus_ack = 1'b1; bus_rdata = $urandom;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk1("stray_ack_done", done, 1'b0);
        chk1("stray_ack_busy", busy, 1'b0);
        chk32("stray_ack_ld", load_data, model_ld);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          hi_cnt;
        bit          seen_fault;
        logic        r, w, u;
        logic [1:0]  sz;
        logic [31:0] a;
        int          kind;
        checks = 0; failures = 0; model_ld = 32'h0;
        reset = 1'b1; start = 1'b0; data_r = 1'b0; data_w = 1'b0; data_size = 2'b00;
        unsigned_value = 1'b0; addr = 32'h0; store_data = 32'h0; bus_rdata = 32'h0;
        bus_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk1("rst_req", bus_req, 1'b0);
        chk1("rst_we", bus_we, 1'b0);
        chk32("rst_ld", load_data, 32'h0);
        chk32("rst_addr", bus_addr, 32'h0);
        chk32("rst_be", 32'(bus_be), 32'h0);
        chk32("rst_wdata", bus_wdata, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 2, 1'b0);
        do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_2002, 32'h0, 32'h1280_3456, 0, 1'b0);
        chk32("lb_value", load_data, 32'hFFFF_FF80);
        do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_2002, 32'h0, 32'h1280_3456, 1, 1'b0);
        chk32("lbu_value", load_data, 32'h0000_0080);
        do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 1'b0);
        chk32("lhu_value", load_data, 32'h0000_BEEF);
        do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 1'b0);
        chk32("lh_value", load_data, 32'hFFFF_BEEF);
        do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2001, 32'h0, 32'h0, 0, 1'b0);
        do_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_2006, 32'h1234_5678, 32'h0, 0, 1'b0);
        do_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_2000, 32'h0, 32'h0, 0, 1'b0);
        chk32("ld_retained", load_data, 32'hFFFF_BEEF);

        // Timeout: no acknowledge at all
        start = 1'b1; data_r = 1'b1; data_w = 1'b0; data_size = 2'b10; addr = 32'h0000_3000;
        @(posedge clk); #1;
        start = 1'b0;
        hi_cnt = 0; seen_fault = 1'b0;
        for (int i = 0; i < 12 && !seen_fault; i++) begin
            if (bus_req) hi_cnt++;
            if (fault) seen_fault = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk1("timeout_fault_seen", seen_fault, 1'b1);
        chk32("timeout_req_cycles", hi_cnt, 32'd4);
        chk1("timeout_not_busy", busy, 1'b0);
        chk1("timeout_no_done", done, 1'b0);
        chk32("timeout_ld_hold", load_data, model_ld);
        @(posedge clk); #1;
        chk1("timeout_fault_pulse", fault, 1'b0);

        // Ack in the last allowed cycle wins over the timeout
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 3, 1'b0);
        chk32("late_ack_value", load_data, 32'hCAFE_F00D);

        // Start during REQ is ignored
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_4002, 32'h0000_9876, 32'h0, 2, 1'b1);
        idle_ack();

        // Reset in the middle of a request
        start = 1'b1; data_r = 1'b1; data_w = 1'b0; data_size = 2'b10; addr = 32'h0000_5000;
        @(posedge clk); #1;
        start = 1'b0;
        chk1("pre_reset_req", bus_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("async_rst_req", bus_req, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        chk1("async_rst_done", done, 1'b0);
        chk1("async_rst_fault", fault, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_ld = 32'h0;
        chk32("rst_clears_ld", load_data, 32'h0);
        do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_5001, 32'h0, 32'h0000_7F00, 0, 1'b0);
        chk32("post_reset_lb", load_data, 32'h0000_007F);

        // Randomized traffic against the reference rules
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 5) begin
                r = 1'b1; w = 1'b0;
            end else if (kind < 9) begin
                r = 1'b0; w = 1'b1;
            end else begin
                r = 1'($urandom); w = r;
            end
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) sz = 2'b11;
            else if (sz == 2'b11) sz = 2'b00;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            u = 1'($urandom);
            kind = int'($urandom_range(0, 3));
            do_op(r, w, sz, u, a, $urandom, $urandom, kind, (kind > 0) && 1'($urandom));
            if ($urandom_range(0, 4) == 0) idle_ack();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Responder for the memory-control outputs of the integer instruction decoder: data_r, data_w, data_size and unsigned_value.
- Executes one load or store per request on the single-master word-wide data bus.
- Generates byte enables and replicated write data; extracts and sign/zero-extends load results.
- Sits between the decoder/ALU (address = ALU result, store data = rs2) and the data memory; load_data feeds rd_data_sel source 01.

Parameters:
- BUS_TIMEOUT, 255: cycles bus_req may stay unacknowledged before fault; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; BUS_TIMEOUT must fit in TO_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request pulse from control for a memory instruction.
- data_r  in  1  load request (decoder).
- data_w  in  1  store request (decoder).
- data_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- unsigned_value  in  1  zero-extend load (LBU/LHU).
- addr  in  32  effective byte address.
- store_data  in  32  rs2 value.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- fault  out  1  one-cycle error pulse (misaligned, illegal, timeout).
- load_data  out  32  extended load result; holds until the next successful load.
- bus_req  out  1  bus request, held until ack.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word address, addr with [1:0] forced to 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  read data, valid with ack.
- bus_ack  in  1  one-cycle acknowledge.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high. All outputs are registered.
- Reset values: every output is 0 and the state is IDLE.
- FSM states: IDLE, REQ, RESP.
- IDLE + start:
  - Latch all inputs.
  - Check legality: exactly one of data_r/data_w set, data_size != 11, half needs addr[0]=0, word needs addr[1:0]=00.
  - Illegal → fault=1 next cycle, no bus activity, stay IDLE.
  - Legal → REQ; bus_req=1 and busy=1 in the next cycle (latency 1).
- start while busy is ignored; no queueing.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<addr[1:0]
  - word: 1111
- Write data:
  - byte: {4{store_data[7:0]}}
  - half: {2{store_data[15:0]}}
  - word: store_data
- bus_we = latched data_w. bus_addr, bus_be, bus_we and bus_wdata are stable for the whole of REQ.
- REQ:
  - The counter counts cycles with bus_req=1.
  - bus_ack=1 → RESP. For a load, capture bus_rdata >> (8*addr[1:0]), then extend from bit 7 (byte) or bit 15 (half); unsigned_value=1 zero-extends.
  - Counter reaches BUS_TIMEOUT without ack (BUS_TIMEOUT≠0) → fault pulse, bus_req drops, return to IDLE; load_data unchanged.
  - Ack and timeout in the same cycle: ack wins.
- RESP: bus_req=0, done=1 for exactly one cycle, load_data valid at the same time, then IDLE.
  - With an ack in cycle k, done is seen in cycle k+1.
  - busy deasserts in the cycle after done.
- Back-to-back: start is accepted again in the first IDLE cycle, giving a minimum 3-cycle throughput with 1-cycle ack.
- bus_ack outside REQ is ignored.
- Reset mid-operation: bus_req, busy, done and fault go to 0 immediately (asynchronously); the in-flight access is abandoned.

Decomposition:
- Shared package lsu_pkg:
  - size constants SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10;
  - the state encoding IDLE/REQ/RESP;
  - byte-enable base masks.
  - The decoder's data_size encoding uses the same constants.
- One combinational sub-module, lsu_lane_align: (size, addr[1:0], store_data, rdata, unsigned) → (be, wdata, extended load value, misaligned).
- The top level keeps the FSM, timeout counter and output registers.

Test Plan:
- SB, addr 0x00001003, store_data 0x000000A5, ack 2 cycles after req → bus_addr 0x00001000, be 1000, wdata 0xA5A5A5A5, we=1; done one cycle after ack; fault=0.
- LB, addr 0x00002002, rdata 0x12803456 → load_data 0xFFFFFF80. Repeat as LBU → 0x00000080.
- LHU, addr 0x00002002, rdata 0xBEEF1234 → be 1100, load_data 0x0000BEEF. Repeat as LH → 0xFFFFBEEF.
- LH at addr 0x00002001, then SW at 0x00002006, then data_size=11 → fault pulse each time, bus_req never asserts, load_data retains its previous value.
- LW at 0x00003000 with BUS_TIMEOUT=4, no ack → bus_req high for exactly 4 cycles, then fault pulse, then IDLE. An ack arriving on the 4th cycle gives done instead of fault.
- start pulsed during REQ is ignored (one bus transaction only). Reset asserted mid-REQ → bus_req and busy are 0 in the same cycle; the next start after reset behaves normally.
